// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage in front of a 256x16 synchronous-read
//            instruction memory. Owns the program counter, drives the memory
//            address, captures the returned word one cycle later into a small
//            skid FIFO and presents {pc, instr} to decode with valid/ready.
//            Branch/jump redirects flush everything fetched but not consumed.
// Ports    : clk            - rising-edge clock shared with the memory
//            rst_n          - asynchronous active-low reset
//            imem_pc        - memory address (combinational from pc_q)
//            imem_rd        - memory data, valid the cycle after sampling
//            out_valid      - head of FIFO holds a valid instruction
//            out_ready      - decode accepts the head this cycle
//            out_pc         - PC of the presented instruction
//            out_instr      - presented instruction word
//            redirect_valid - single-cycle taken-branch/jump pulse
//            redirect_pc    - redirect target, sampled with redirect_valid
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int              PC_W       = 8,
  parameter int              INSTR_W    = 16,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2     // supported range 2..4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc
);

  localparam int               CNT_W     = $clog2(FIFO_DEPTH + 1);
  // One extra bit so count + inflight can never wrap before the compare.
  localparam int               OCC_W     = CNT_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

  // Architectural state
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               inflight_q, inflight_d;
  logic [PC_W-1:0]    infl_pc_q, infl_pc_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // FIFO storage: entry 0 is always the head, so pops shift the array down.
  logic [PC_W-1:0]    fifo_pc_q    [FIFO_DEPTH];
  logic [PC_W-1:0]    fifo_pc_d    [FIFO_DEPTH];
  logic [INSTR_W-1:0] fifo_instr_q [FIFO_DEPTH];
  logic [INSTR_W-1:0] fifo_instr_d [FIFO_DEPTH];

  // Combinational helpers
  logic               w_pop;
  logic               w_push;
  logic               w_issue;
  logic [OCC_W-1:0]   w_occ;
  logic [CNT_W-1:0]   w_wr_idx;

  assign imem_pc   = pc_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = fifo_pc_q[0];
  assign out_instr = fifo_instr_q[0];

  always_comb begin
    w_pop    = out_valid & out_ready;
    w_push   = inflight_q;
    // Occupancy the FIFO would reach if we issued now: entries already held,
    // plus the word returning next edge, minus the one decode is taking.
    w_occ    = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(w_pop);
    w_issue  = !redirect_valid && (w_occ < DEPTH_OCC);
    // After the shift caused by a pop, the first free slot moves down by one.
    w_wr_idx = count_q - CNT_W'(w_pop);

    pc_d         = pc_q;
    inflight_d   = 1'b0;
    infl_pc_d    = infl_pc_q;
    count_d      = count_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;

    if (redirect_valid) begin
      // Flush wins over everything: the word returning next cycle is dropped
      // because inflight_d stays 0. A concurrent pop still completes at the
      // decode side since out_* were valid this cycle.
      pc_d    = redirect_pc;
      count_d = '0;
    end else begin
      if (w_issue) begin
        pc_d       = pc_q + PC_W'(1);
        inflight_d = 1'b1;
        infl_pc_d  = pc_q;
      end

      if (w_pop) begin
        for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
          fifo_pc_d[i]    = fifo_pc_q[i+1];
          fifo_instr_d[i] = fifo_instr_q[i+1];
        end
      end

      if (w_push) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          if (CNT_W'(i) == w_wr_idx) begin
            fifo_pc_d[i]    = infl_pc_q;
            fifo_instr_d[i] = imem_rd;
          end
        end
      end

      count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      infl_pc_q  <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
      end
    end else begin
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      infl_pc_q    <= infl_pc_d;
      count_q      <= count_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
    end
  end

  // The issue rule reserves a slot for every word in flight, so a push into a
  // full FIFO without a matching pop indicates a broken occupancy calculation.
  a_no_overflow : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(!redirect_valid && w_push && !w_pop && (count_q == DEPTH_CNT))
  );

endmodule
`default_nettype wire
